// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit: opcode and FSM
// encodings plus the issue-to-result latency of the iterative datapath.
package mips_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  localparam int MDU_WIDTH   = 32;
  // Edges from issue to the end of the DONE cycle: WIDTH steps + FIX + DONE.
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative 2*WIDTH accumulator: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle. Divide step needs MDU_DIV_EN.
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic               i_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: {upper, multiplier} shifts right, upper accumulates the multiplicand.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_DIV_EN
  logic [WIDTH:0] w_diff;

  // Divide: {remainder, dividend} shifts left; a non-negative trial keeps the difference.
  assign w_diff     = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_a};
  assign w_div_next = w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
`else
  assign w_div_next = r_acc;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_a   <= i_a;
      r_acc <= {{WIDTH{1'b0}}, i_b};
    end else if (i_step) begin
      r_acc <= i_div ? w_div_next : w_mul_next;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mult_div_unit.sv
// MIPS multiply/divide unit with architectural HI/LO. Divide support is built
// only when MDU_DIV_EN is defined; otherwise DIV/DIVU are no-ops.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_d,
  input  logic [WIDTH-1:0] rt_d,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t         r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div, r_div0, r_neg_q, r_neg_r;
  logic [WIDTH-1:0]   r_rs, r_hi, r_lo;
  logic               w_is_mul, w_is_div, w_signed, w_idle, w_accept;
  logic               w_load, w_step, w_fix;
  logic [WIDTH-1:0]   w_rs_mag, w_rt_mag, w_quot_mag, w_rem_mag, w_quot, w_rem;
  logic [2*WIDTH-1:0] w_acc, w_prod;

  assign w_is_mul = (op == MULT) || (op == MULTU);
`ifdef MDU_DIV_EN
  assign w_is_div = (op == DIV) || (op == DIVU);
`else
  assign w_is_div = 1'b0;
`endif
  assign w_signed = (op == MULT) || (op == DIV);
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && start && (w_is_mul || w_is_div);

  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  assign w_rs_mag = (w_signed && rs_d[WIDTH-1]) ? -rs_d : rs_d;
  assign w_rt_mag = (w_signed && rt_d[WIDTH-1]) ? -rt_d : rt_d;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_step (w_step),
    .i_div  (r_div),
    .i_a    (w_rt_mag),
    .i_b    (w_rs_mag),
    .o_acc  (w_acc)
  );

  assign w_prod     = r_neg_q ? -w_acc : w_acc;
  assign w_quot_mag = w_acc[WIDTH-1:0];
  assign w_rem_mag  = w_acc[2*WIDTH-1:WIDTH];
  assign w_quot     = r_neg_q ? -w_quot_mag : w_quot_mag;
  assign w_rem      = r_neg_r ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Flush wins over both the iteration and the FIX write.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_next = RUN;
        w_load       = 1'b1;
      end
      RUN: if (flush) begin
        w_state_next = IDLE;
      end else begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = FIX;
      end
      FIX: if (flush) begin
        w_state_next = IDLE;
      end else begin
        w_fix        = 1'b1;
        w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_div0  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_rs    <= '0;
    end else if (w_load) begin
      r_cnt   <= '0;
      r_div   <= w_is_div;
      r_div0  <= (rt_d == '0);
      r_neg_q <= w_signed && (rs_d[WIDTH-1] ^ rt_d[WIDTH-1]);
      r_neg_r <= w_signed && rs_d[WIDTH-1];
      r_rs    <= rs_d;
    end else if (w_step) begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_idle && start && (op == MTHI)) begin
      r_hi <= rs_d;
    end else if (w_idle && start && (op == MTLO)) begin
      r_lo <= rs_d;
    end else if (w_fix) begin
      if (!r_div) begin
        {r_hi, r_lo} <= w_prod;
      end else if (r_div0) begin
        r_hi <= r_rs;
        r_lo <= '1;
      end else begin
        r_hi <= w_rem;
        r_lo <= w_quot;
      end
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus queues expected {hi,lo}, a
// monitor checks them on every done pulse. Adapts to the MDU_DIV_EN build.
module tb_mult_div_unit;
  import mips_pkg::*;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_d, rt_d;
  logic        flush;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [63:0] sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_fail   = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rs_d  (rs_d),
    .rt_d  (rt_d),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {hi, lo}, 64'hx);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        $display("txn done: hi=%h lo=%h (expected hi=%h lo=%h)", hi, lo, exp[63:32], exp[31:0]);
        chk("result_hi", {32'd0, hi}, {32'd0, exp[63:32]});
        chk("result_lo", {32'd0, lo}, {32'd0, exp[31:0]});
      end
    end
  end

  task automatic run_op(input string name, input logic [2:0] t_op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    bit expect_run;
    bit gap;
    int cyc;
    expect_run = 1'b1;
    if (!DIV_EN && (t_op == DIV || t_op == DIVU)) expect_run = 1'b0;
    @(negedge clk);
    start = 1'b1; op = t_op; rs_d = a; rt_d = b;
    if (expect_run) sb.push_back({eh, el});
    @(posedge clk); #1;
    start = 1'b0; rs_d = $urandom; rt_d = $urandom;
    $display("txn issue %s: op=%0d rs=%h rt=%h run=%0d", name, t_op, a, b, expect_run);
    if (expect_run) begin
      chk({name, "_busy_e0"}, busy, 1);
      cyc = 0; gap = 1'b0;
      while (done !== 1'b1 && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (busy !== 1'b1) gap = 1'b1;
      end
      chk({name, "_latency"}, cyc, MDU_LATENCY - 1);
      chk({name, "_busy_gap"}, gap, 0);
      @(posedge clk); #1;
      chk({name, "_busy_drop"}, busy, 0);
      m_hi = eh; m_lo = el;
    end else begin
      chk({name, "_nop_busy"}, busy, 0);
      chk({name, "_nop_hi"}, hi, m_hi);
      chk({name, "_nop_lo"}, lo, m_lo);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; rs_d = '0; rt_d = '0; flush = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op("mult_neg",  MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("mult_min",  MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op("multu_sh",  MULTU, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780);
    run_op("div_neg",   DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negd",  DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu_zero", DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_op("div_zero",  DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_op("div_ovf",   DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // MTHI then MTLO on consecutive edges
    @(negedge clk);
    start = 1'b1; op = MTHI; rs_d = 32'h12345678;
    @(posedge clk); #1;
    m_hi = 32'h12345678;
    $display("txn issue mthi: rs=%h", rs_d);
    chk("mthi_hi", hi, m_hi);
    chk("mthi_busy", busy, 0);
    op = MTLO; rs_d = 32'hCAFEBABE;
    @(posedge clk); #1;
    start = 1'b0;
    m_lo = 32'hCAFEBABE;
    $display("txn issue mtlo: rs=%h", rs_d);
    chk("mtlo_lo", lo, m_lo);
    chk("mtlo_hi", hi, m_hi);
    chk("mtlo_busy", busy, 0);
    chk("mtlo_done", done, 0);

    // Undefined opcode is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd6; rs_d = 32'h55555555; rt_d = 32'h3;
    @(posedge clk); #1;
    start = 1'b0;
    $display("txn issue undefined op 6");
    chk("undef_busy", busy, 0);
    chk("undef_hi", hi, m_hi);
    chk("undef_lo", lo, m_lo);

    // MULTU flushed at E10; a start during busy at E5 must be ignored
    @(negedge clk);
    start = 1'b1; op = MULTU; rs_d = 32'h0000FFFF; rt_d = 32'h00010001;
    @(posedge clk); #1;
    start = 1'b0;
    $display("txn issue multu_flush");
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = MTHI; rs_d = 32'hDEADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    chk("flush_busy_e5", busy, 1);
    chk("flush_e5_hi", hi, m_hi);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, m_hi);
    chk("flush_lo", lo, m_lo);
    repeat (40) @(posedge clk);
    #1;
    chk("flush_hi_late", hi, m_hi);
    chk("flush_lo_late", lo, m_lo);

    // Asynchronous reset in the middle of a long operation
    @(negedge clk);
    start = 1'b1; op = DIV_EN ? DIV : MULT; rs_d = 32'd1000; rt_d = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    $display("txn issue op=%0d interrupted by reset", op);
    repeat (19) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0;
    chk("arst_hi", hi, m_hi);
    chk("arst_lo", lo, m_lo);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("divu_small", DIVU, 32'd9, 32'd4, 32'd1, 32'd2);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
